// File: rtl/i2c_slave.sv
// I2C target with 7-bit address, byte write and optional byte read.
// Read support is built only when I2C_SLAVE_READ_EN is defined.
`timescale 1ns/1ps
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h4C
) (
  input  logic       clk100mhz,
  input  logic       res,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ADDR      = 3'd1;
  localparam logic [2:0] ADDR_ACK  = 3'd2;
  localparam logic [2:0] WRITE     = 3'd3;
  localparam logic [2:0] WRITE_ACK = 3'd4;
  localparam logic [2:0] READ      = 3'd5;
  localparam logic [2:0] READ_ACK  = 3'd6;
  localparam logic [2:0] IGNORE    = 3'd7;

  logic       scl_s1_q, scl_s2_q, scl_h_q;
  logic       sda_s1_q, sda_s2_q, sda_h_q;
  logic [2:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d;
  logic       drv_q, drv_d;
  logic       pend_q, pend_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_req_q, tx_req_d;
  logic       busy_q, busy_d;

  logic scl_rise, scl_fall, start_w, stop_w;
  logic [7:0] byte_w;
  logic       match_w;

  assign scl_rise = scl_s2_q & ~scl_h_q;
  assign scl_fall = ~scl_s2_q & scl_h_q;
  assign start_w  = scl_s2_q & scl_h_q & ~sda_s2_q & sda_h_q;
  assign stop_w   = scl_s2_q & scl_h_q & sda_s2_q & ~sda_h_q;
  assign byte_w   = {sh_q[6:0], sda_s2_q};
  assign match_w  = (sh_q[6:0] == SLAVE_ADDR);

  // Bus events gate the driver combinationally so release is immediate.
  assign sda = (drv_q && !start_w && !stop_w) ? 1'b0 : 1'bz;

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_req   = tx_req_q;
  assign busy     = busy_q;

`ifndef I2C_SLAVE_READ_EN
  logic unused_rd;
  assign unused_rd = ^{tx_data, sh_q[7]};
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    drv_d      = drv_q;
    pend_d     = pend_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    busy_d     = busy_q;
    if (stop_w) begin
      state_d = IDLE;
      cnt_d   = 3'd0;
      drv_d   = 1'b0;
      pend_d  = 1'b0;
      busy_d  = 1'b0;
    end else if (start_w) begin
      state_d = ADDR;
      cnt_d   = 3'd0;
      drv_d   = 1'b0;
      pend_d  = 1'b0;
    end else begin
      case (state_q)
        ADDR: if (scl_rise) begin
          sh_d  = byte_w;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
`ifdef I2C_SLAVE_READ_EN
            if (match_w) begin
`else
            if (match_w && !sda_s2_q) begin
`endif
              state_d = ADDR_ACK;
              busy_d  = 1'b1;
            end else begin
              state_d = IGNORE;
            end
          end
        end
        ADDR_ACK: if (scl_fall) begin
          if (!drv_q) begin
            drv_d = 1'b1;
          end else begin
            drv_d = 1'b0;
            cnt_d = 3'd0;
`ifdef I2C_SLAVE_READ_EN
            if (sh_q[0]) begin
              state_d  = READ;
              sh_d     = tx_data;
              tx_req_d = 1'b1;
              drv_d    = ~tx_data[7];
            end else begin
              state_d = WRITE;
            end
`else
            state_d = WRITE;
`endif
          end
        end
        WRITE: if (scl_rise) begin
          sh_d  = byte_w;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            rx_data_d  = byte_w;
            rx_valid_d = 1'b1;
            state_d    = WRITE_ACK;
          end
        end
        WRITE_ACK: if (scl_fall) begin
          if (!drv_q) begin
            drv_d = 1'b1;
          end else begin
            drv_d   = 1'b0;
            cnt_d   = 3'd0;
            state_d = WRITE;
          end
        end
`ifdef I2C_SLAVE_READ_EN
        READ: begin
          if (scl_rise) cnt_d = cnt_q + 3'd1;
          if (scl_fall) begin
            if (pend_q) begin
              pend_d = 1'b0;
              drv_d  = ~sh_q[7];
            end else if (cnt_q == 3'd0) begin
              drv_d   = 1'b0;
              state_d = READ_ACK;
            end else begin
              sh_d  = {sh_q[6:0], 1'b0};
              drv_d = ~sh_q[6];
            end
          end
        end
        READ_ACK: if (scl_rise) begin
          if (!sda_s2_q) begin
            state_d  = READ;
            sh_d     = tx_data;
            tx_req_d = 1'b1;
            cnt_d    = 3'd0;
            pend_d   = 1'b1;
          end else begin
            state_d = IGNORE;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk100mhz or negedge res) begin
    if (!res) begin
      scl_s1_q   <= 1'b1;
      scl_s2_q   <= 1'b1;
      scl_h_q    <= 1'b1;
      sda_s1_q   <= 1'b1;
      sda_s2_q   <= 1'b1;
      sda_h_q    <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      sh_q       <= 8'h00;
      drv_q      <= 1'b0;
      pend_q     <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      scl_s1_q   <= scl;
      scl_s2_q   <= scl_s1_q;
      scl_h_q    <= scl_s2_q;
      sda_s1_q   <= sda;
      sda_s2_q   <= sda_s1_q;
      sda_h_q    <= sda_s2_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      drv_q      <= drv_d;
      pend_q     <= pend_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
      busy_q     <= busy_d;
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Scoreboard bench for i2c_slave: bus-level master, queue-based
// expectations for rx_valid/tx_req, ACK and read-bit checks inline.
`timescale 1ns/1ps
module tb_i2c_slave;

  localparam logic [6:0] SA = 7'h4C;
`ifdef I2C_SLAVE_READ_EN
  localparam bit RD_EN = 1'b1;
`else
  localparam bit RD_EN = 1'b0;
`endif
  localparam int Q = 100;

  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  logic [7:0] tx_data = 8'h00;
  wire        sda;
  wire  [7:0] rx_data;
  wire        rx_valid, tx_req, busy;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_slave #(.SLAVE_ADDR(SA)) dut (
    .clk100mhz(clk),
    .res(res),
    .scl(scl),
    .sda(sda),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .tx_data(tx_data),
    .tx_req(tx_req),
    .busy(busy)
  );

  int total = 0;
  int passed = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] exp_tx[$];
  logic [7:0] mon_e;
  bit dut_low_seen = 1'b0;

  task automatic chk(input bit ok, input string nm,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a strobe.
  always @(negedge clk) begin
    if (!m_low && sda === 1'b0) dut_low_seen = 1'b1;
    if (rx_valid) begin
      chk(exp_rx.size() != 0, "rx_valid_unexpected", rx_data, 0);
      if (exp_rx.size() != 0) begin
        mon_e = exp_rx.pop_front();
        chk(rx_data == mon_e, "rx_data", rx_data, mon_e);
      end
    end
    if (tx_req) begin
      chk(exp_tx.size() != 0, "tx_req_unexpected", tx_data, 0);
      if (exp_tx.size() != 0) begin
        mon_e = exp_tx.pop_front();
        chk(tx_data == mon_e, "tx_req_data", tx_data, mon_e);
      end
    end
  end

  function automatic bit addr_ack(input logic [7:0] a);
    return (a[7:1] == SA) && (!a[0] || RD_EN);
  endfunction

  task automatic bit_w(input bit b);
    m_low = !b; #Q;
    scl = 1'b1; #Q; #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic bit_r(output bit b);
    m_low = 1'b0; #Q;
    scl = 1'b1; #Q;
    b = sda; #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic start_c();
    m_low = 1'b0; #Q;
    scl = 1'b1; #Q;
    m_low = 1'b1; #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic stop_c();
    m_low = 1'b1; #Q;
    scl = 1'b1; #Q;
    m_low = 1'b0; #Q; #Q;
    chk(busy == 1'b0, "busy_after_stop", busy, 0);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit ack, input string nm);
    bit a;
    for (int i = 7; i >= 0; i--) bit_w(b[i]);
    bit_r(a);
    chk(a == !ack, nm, a, !ack);
  endtask

  task automatic write_txn(input logic [7:0] addr, input int n, input logic [7:0] first);
    bit ok;
    logic [7:0] d;
    ok = addr_ack(addr);
    start_c();
    send_byte(addr, ok, "addr_ack");
    chk(busy == ok, "busy_addr", busy, ok);
    for (int k = 0; k < n; k++) begin
      d = (k == 0) ? first : 8'($urandom);
      if (ok) exp_rx.push_back(d);
      send_byte(d, ok, "data_ack");
    end
    stop_c();
  endtask

  task automatic read_txn(input int n, input logic [7:0] first);
    bit ok, b;
    logic [7:0] got, cur;
    ok = RD_EN;
    tx_data = first;
    if (ok) exp_tx.push_back(first);
    start_c();
    send_byte({SA, 1'b1}, ok, "rd_addr_ack");
    if (ok) begin
      chk(busy == 1'b1, "busy_read", busy, 1);
      for (int k = 0; k < n; k++) begin
        cur = tx_data;
        for (int i = 7; i >= 0; i--) begin
          bit_r(b);
          got[i] = b;
        end
        chk(got == cur, "rd_byte", got, cur);
        if (k < n - 1) begin
          tx_data = 8'($urandom);
          exp_tx.push_back(tx_data);
          bit_w(1'b0);
        end else begin
          bit_w(1'b1);
          chk(sda == 1'b1, "nack_release", sda, 1);
        end
      end
    end
    stop_c();
  endtask

  task automatic rstart_txn(input logic [7:0] d);
    start_c();
    send_byte({SA, 1'b0}, 1'b1, "rs_addr1_ack");
    for (int i = 0; i < 4; i++) bit_w(1'($urandom));
    start_c();
    send_byte({SA, 1'b0}, 1'b1, "rs_addr2_ack");
    exp_rx.push_back(d);
    send_byte(d, 1'b1, "rs_data_ack");
    stop_c();
  endtask

  task automatic reset_txn();
    logic [7:0] a;
    a = {SA, 1'b0};
    start_c();
    for (int i = 7; i >= 0; i--) bit_w(a[i]);
    m_low = 1'b0; #Q;
    chk(sda == 1'b0, "ack_before_reset", sda, 0);
    res = 1'b0; #1;
    chk(sda == 1'b1, "reset_releases_sda", sda, 1);
    chk(busy == 1'b0, "reset_busy", busy, 0);
    chk(rx_data == 8'h00, "reset_rx_data", rx_data, 0);
    #(Q - 1);
    res = 1'b1;
    scl = 1'b1; #Q; #Q;
    scl = 1'b0; #Q;
    dut_low_seen = 1'b0;
    send_byte(8'h55, 1'b0, "post_reset_ack");
    stop_c();
    chk(dut_low_seen == 1'b0, "post_reset_quiet", dut_low_seen, 0);
  endtask

  initial begin
    logic [7:0] a;
    #3;
    chk(sda == 1'b1, "rst_sda", sda, 1);
    chk(busy == 1'b0, "rst_busy", busy, 0);
    chk(rx_valid == 1'b0, "rst_rx_valid", rx_valid, 0);
    chk(tx_req == 1'b0, "rst_tx_req", tx_req, 0);
    chk(rx_data == 8'h00, "rst_rx_data", rx_data, 0);
    #20 res = 1'b1;
    #Q;

    write_txn({SA, 1'b0}, 1, 8'h55);
    chk(rx_data == 8'h55, "write_rx_data", rx_data, 8'h55);

    dut_low_seen = 1'b0;
    write_txn(8'h9A, 1, 8'hFF);
    chk(dut_low_seen == 1'b0, "mismatch_quiet", dut_low_seen, 0);

    dut_low_seen = 1'b0;
    read_txn(1, 8'hA5);
    if (!RD_EN) chk(dut_low_seen == 1'b0, "rd_disabled_quiet", dut_low_seen, 0);

    rstart_txn(8'h3C);
    chk(rx_data == 8'h3C, "rstart_rx_data", rx_data, 8'h3C);

    reset_txn();
    write_txn({SA, 1'b0}, 1, 8'hC3);

    for (int t = 0; t < 12; t++) begin
      case ($urandom_range(0, 3))
        0: begin
          a = ($urandom_range(0, 1) == 1) ? {SA, 1'b0} : {7'($urandom), 1'b0};
          write_txn(a, $urandom_range(1, 3), 8'($urandom));
        end
        1: read_txn($urandom_range(1, 3), 8'($urandom));
        2: rstart_txn(8'($urandom));
        default: write_txn({SA, 1'b0}, $urandom_range(2, 4), 8'($urandom));
      endcase
    end

    #(4 * Q);
    chk(exp_rx.size() == 0, "rx_pending", exp_rx.size(), 0);
    chk(exp_tx.size() == 0, "tx_pending", exp_tx.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/i2c_slave.md
I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h4C, the 7-bit target address matched against bits [7:1] of the address byte.
REQ-002 SHALL have port clk100mhz  input  1  system clock, 100 MHz; all logic runs on its rising edge.
REQ-003 SHALL have port res  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port scl  input  1  I2C clock from the bus.
REQ-005 SHALL have port sda  inout  1  I2C data, open-drain: driven 0 or high-Z only, never 1.
REQ-006 SHALL have port rx_data  output  8  last write byte received, MSB first on the bus.
REQ-007 SHALL have port rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-008 SHALL have port tx_data  input  8  byte returned on a read; sampled when tx_req is asserted.
REQ-009 SHALL have port tx_req  output  1  one-cycle pulse when tx_data is captured.
REQ-010 SHALL have port busy  output  1  high from an address-matched START until STOP.

Function
REQ-011 SHALL pass scl and sda through 2-flop synchronizers, plus one history flop for edge detection; edge-to-action latency is 3 clk100mhz cycles.
REQ-012 SHALL detect START as a synchronized sda fall while synchronized scl is high, and STOP as an sda rise while scl is high.
REQ-013 SHALL implement states IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK and IGNORE.
REQ-014 SHALL enter ADDR on START from any state, including a repeated START mid-byte, and clear the bit counter.
REQ-015 SHALL enter IDLE on STOP from any state, release sda and deassert busy.
REQ-016 SHALL sample sda on each scl rising edge; the 3-bit counter wraps after bit 8.
REQ-017 On the 8th address bit: if bits [7:1] equal SLAVE_ADDR, go to ADDR_ACK and set busy; otherwise go to IGNORE and never drive sda until the next START or STOP.
REQ-018 ACK SHALL be driven (sda=0) from the scl falling edge after bit 8 until the next scl falling edge, then released.
REQ-019 After ADDR_ACK, R/W=0 SHALL go to WRITE and R/W=1 SHALL go to READ.
REQ-020 In WRITE, after bit 8 rx_data SHALL update and rx_valid SHALL pulse for 1 cycle at the same edge; the block then goes to WRITE_ACK (always ACK), then back to WRITE for further bytes.
REQ-021 On READ entry, tx_req SHALL pulse and tx_data SHALL be latched.
REQ-022 In READ, bits SHALL be shifted out MSB first, with sda changed only after scl falling edges; a 1 bit releases sda and a 0 bit drives it low.
REQ-023 In READ_ACK, the block SHALL sample the master's ACK on scl rise: ACK (0) returns to READ, reloading and pulsing tx_req; NACK (1) goes to IGNORE.
REQ-024 A STOP or START arriving while the block drives sda SHALL release sda in the same cycle the event is detected.

Reset
REQ-025 While res=0, the block SHALL be in IDLE with sda high-Z, rx_data=8'h00, rx_valid=0, tx_req=0, busy=0, shift and bit counters 0, and synchronizer flops set to 1.
REQ-026 Reset deasserted mid-transfer SHALL leave the block in IDLE until a fresh START; all bus traffic before that START is ignored.

Configuration
REQ-027 The macro I2C_SLAVE_READ_EN SHALL control read support.
- Defined: READ, READ_ACK, tx_data and tx_req are functional.
- Undefined: an address with R/W=1 is NACKed (no ACK driven), the block goes to IGNORE, tx_req stays 0 and tx_data is unused.

Verification
REQ-028 Write: START, 0x98, 0x55, STOP -> ACK after each byte; rx_data=8'h55; rx_valid pulses exactly once; busy falls after STOP.
REQ-029 Address mismatch: START, 0x9A, 0xFF, STOP -> sda never driven low by the DUT; rx_valid never pulses; busy stays 0.
REQ-030 Read (macro defined): tx_data=8'hA5; START, 0x99 -> ACK, then sda bits 1,0,1,0,0,1,0,1; master NACK -> DUT releases sda; exactly one tx_req pulse.
REQ-031 Repeated START: START, 0x98, 4 bits of data, START, 0x98, 0x3C, STOP -> the partial byte is discarded; rx_data=8'h3C; one rx_valid pulse.
REQ-032 res=0 asserted while the DUT drives ACK -> sda high-Z immediately; after release, the block stays idle until the next START.
REQ-033 Macro undefined: START, 0x99 -> no ACK (sda stays high-Z); tx_req=0.
